// File: rtl/main_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : main_decoder
// Description : LEGv8 single-cycle main control decoder with exception status
//               and an exception-mode flag that masks external interrupts.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module main_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        ExtIRQ,
  output logic        Reg2Loc,
  output logic [1:0]  ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        ERet,
  output logic [3:0]  EStatus
);

  localparam logic [3:0] C_EST_NONE    = 4'b0000;
  localparam logic [3:0] C_EST_EXTIRQ  = 4'b0001;
  localparam logic [3:0] C_EST_INVALID = 4'b0010;

  // {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet, ALUOp}
  logic [10:0] w_ctrl;
  logic        w_valid;
  logic [3:0]  w_estatus;
  logic        r_excmode;

  always_comb begin
    w_ctrl  = 11'b0;
    w_valid = 1'b1;
    casez (Op)
      11'b11111000010: w_ctrl = 11'b0_01_1_1_1_0_0_0_00;  // LDUR
      11'b11111000000: w_ctrl = 11'b1_01_0_0_0_1_0_0_00;  // STUR
      11'b10110100???: w_ctrl = 11'b1_00_0_0_0_0_1_0_01;  // CBZ
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: w_ctrl = 11'b0_00_0_1_0_0_0_0_10;  // ADD/SUB/AND/ORR
      11'b1001000100?,
      11'b1101000100?: w_ctrl = 11'b0_10_0_1_0_0_0_0_10;  // ADDI/SUBI
      11'b11010110100: w_ctrl = 11'b0_00_0_0_0_0_0_1_01;  // ERET
      default:         w_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_estatus = C_EST_NONE;
    if (!reset)
      w_estatus = C_EST_NONE;
    else if (!w_valid)
      w_estatus = C_EST_INVALID;
    else if (ExtIRQ && !r_excmode)
      w_estatus = C_EST_EXTIRQ;
  end

  // Reset gates the outputs combinationally so assertion takes effect mid-cycle.
  assign {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet, ALUOp} =
         reset ? w_ctrl : 11'b0;
  assign EStatus = w_estatus;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_excmode <= 1'b0;
    else if (w_estatus != C_EST_NONE)
      r_excmode <= 1'b1;
    else if (ERet)
      r_excmode <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_main_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_main_decoder
// Description : Scoreboard bench for main_decoder against a table-driven model.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_main_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] Op = 11'b0;
  logic        ExtIRQ = 1'b0;
  logic        Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet;
  logic [1:0]  ALUSrc, ALUOp;
  logic [3:0]  EStatus;

  main_decoder dut (
    .clk(clk), .reset(reset), .Op(Op), .ExtIRQ(ExtIRQ),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .ERet(ERet), .EStatus(EStatus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] exp;
    int          tag;
  } sb_item_t;

  sb_item_t sb[$];
  event     ev_check;
  int       total = 0;
  int       bad = 0;
  logic     m_exc = 1'b0;

  // Reference decode table: value, don't-care mask, controls
  // controls = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet, ALUOp}
  logic [10:0] t_val  [10];
  logic [10:0] t_mask [10];
  logic [10:0] t_ctl  [10];

  function automatic logic [14:0] ref_out(input logic [10:0] op, input logic irq,
                                          input logic rst, input logic exc);
    logic [10:0] ctl;
    bit          hit;
    ctl = 11'b0;
    hit = 1'b0;
    if (!rst) return 15'b0;
    for (int i = 0; i < 10; i++)
      if (!hit && ((op & t_mask[i]) == t_val[i])) begin
        hit = 1'b1;
        ctl = t_ctl[i];
      end
    if (!hit) return {11'b0, 4'd2};
    return {ctl, (irq && !exc) ? 4'd1 : 4'd0};
  endfunction

  // Model exception flag: enter on any nonzero cause, leave on ERET.
  always @(posedge clk or negedge reset) begin
    logic [14:0] r;
    if (!reset) m_exc = 1'b0;
    else begin
      r = ref_out(Op, ExtIRQ, reset, m_exc);
      if (r[3:0] != 4'd0) m_exc = 1'b1;
      else if (r[6]) m_exc = 1'b0;
    end
  end

  // Monitor: compares DUT outputs against the oldest scoreboard entry.
  initial begin
    sb_item_t    it;
    logic [14:0] got;
    forever begin
      @(ev_check);
      got = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet, ALUOp, EStatus};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got=%b required=<queued entry>", got);
      end else begin
        it = sb.pop_front();
        if (got !== it.exp) begin
          bad++;
          $display("FAIL step%0d: got=%b required=%b (op=%b irq=%b rst=%b)",
                   it.tag, got, it.exp, Op, ExtIRQ, reset);
        end
      end
    end
  end

  int step_no = 0;

  task automatic apply(input logic [10:0] op, input logic irq, input logic rst);
    sb_item_t it;
    @(negedge clk);
    Op = op;
    ExtIRQ = irq;
    reset = rst;
    #1;
    it.exp = ref_out(op, irq, rst, m_exc);
    it.tag = step_no++;
    sb.push_back(it);
    ->ev_check;
    #1;
  endtask

  localparam logic [10:0] LDUR = 11'b11111000010, STUR = 11'b11111000000;
  localparam logic [10:0] CBZ = 11'b10110100101, ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000, ANDR = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000, ADDI = 11'b10010001000;
  localparam logic [10:0] SUBI = 11'b11010001001, ERETO = 11'b11010110100;

  initial begin
    logic [10:0] ops [10];
    t_val[0] = LDUR;          t_mask[0] = 11'h7FF; t_ctl[0] = 11'b0_01_1_1_1_0_0_0_00;
    t_val[1] = STUR;          t_mask[1] = 11'h7FF; t_ctl[1] = 11'b1_01_0_0_0_1_0_0_00;
    t_val[2] = 11'b10110100000; t_mask[2] = 11'b11111111000; t_ctl[2] = 11'b1_00_0_0_0_0_1_0_01;
    t_val[3] = ADD;           t_mask[3] = 11'h7FF; t_ctl[3] = 11'b0_00_0_1_0_0_0_0_10;
    t_val[4] = SUB;           t_mask[4] = 11'h7FF; t_ctl[4] = 11'b0_00_0_1_0_0_0_0_10;
    t_val[5] = ANDR;          t_mask[5] = 11'h7FF; t_ctl[5] = 11'b0_00_0_1_0_0_0_0_10;
    t_val[6] = ORR;           t_mask[6] = 11'h7FF; t_ctl[6] = 11'b0_00_0_1_0_0_0_0_10;
    t_val[7] = 11'b10010001000; t_mask[7] = 11'b11111111110; t_ctl[7] = 11'b0_10_0_1_0_0_0_0_10;
    t_val[8] = 11'b11010001000; t_mask[8] = 11'b11111111110; t_ctl[8] = 11'b0_10_0_1_0_0_0_0_10;
    t_val[9] = ERETO;         t_mask[9] = 11'h7FF; t_ctl[9] = 11'b0_00_0_0_0_0_0_1_01;
    ops = '{LDUR, STUR, CBZ, ADD, SUB, ANDR, ORR, ADDI, SUBI, ERETO};

    // Reset state
    apply(LDUR, 1'b1, 1'b0);
    // Full decode table, no interrupt
    for (int i = 0; i < 10; i++) apply(ops[i], 1'b0, 1'b1);
    // Invalid opcode enters exception mode, masking the next interrupt
    apply(11'h7FF, 1'b1, 1'b1);
    apply(ADD, 1'b1, 1'b1);
    apply(ERETO, 1'b0, 1'b1);
    // Interrupt on valid instruction, return, interrupt again
    apply(ADD, 1'b1, 1'b1);
    apply(ERETO, 1'b0, 1'b1);
    apply(ADD, 1'b1, 1'b1);
    // Asynchronous reset while in exception mode
    apply(LDUR, 1'b0, 1'b1);
    apply(LDUR, 1'b0, 1'b0);
    apply(LDUR, 1'b1, 1'b1);
    apply(ERETO, 1'b0, 1'b1);
    // Boundary opcodes
    apply(11'b11111000011, 1'b0, 1'b1);
    apply(11'b10001011001, 1'b0, 1'b1);
    apply(11'b10110100000, 1'b0, 1'b1);
    apply(11'b10110100111, 1'b0, 1'b1);
    apply(ERETO, 1'b0, 1'b1);
    // Randomized mix of table opcodes and arbitrary values
    for (int n = 0; n < 300; n++) begin
      logic [10:0] op;
      logic        rst;
      if ($urandom_range(0, 2) != 0) op = ops[$urandom_range(0, 9)];
      else op = 11'($urandom);
      rst = ($urandom_range(0, 29) != 0);
      apply(op, 1'($urandom), rst);
    end
    #5;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: got=%0d pending required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
